// File: rtl/cam_dvp_tx.sv
// Sensor-side DVP transmitter with OV7660-style frame timing. RGB565 pixels are sent high byte
// first, from a valid/ready stream or an internal test pattern. Everything runs on pclk.
module cam_dvp_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        tp_en,
  input  logic [15:0] pix,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_dout,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] underflow_cnt,
  output logic        underflow_err
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned V_MAX_A  = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
  localparam int unsigned V_MAX_B  = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
  localparam int unsigned V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int unsigned HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  logic [2:0]    r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_tp_mode;
  logic          r_stop_pend;
  logic [7:0]    r_lo;
  logic          r_vsync;
  logic          r_href;
  logic [7:0]    r_dout;
  logic          r_busy;
  logic [15:0]   r_frame_cnt;
  logic [15:0]   r_uf_cnt;
  logic          r_uf_err;

  logic [2:0]    w_state_n;
  logic [HW-1:0] w_h_n;
  logic [VW-1:0] w_v_n;
  logic [VW-1:0] w_v_lastidx;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_vs_n;
  logic          w_hr_n;
  logic [15:0]   w_tp_pix;
  logic [7:0]    w_dout_n;
  logic [7:0]    w_lo_n;
  logic          w_starve;
  logic          w_tp_load;

  always_comb begin
    w_v_lastidx = '0;
    case (r_state)
      S_VSYNC:  w_v_lastidx = VW'(VSYNC_LINES - 1);
      S_VBACK:  w_v_lastidx = VW'(V_BACK - 1);
      S_ACTIVE: w_v_lastidx = VW'(V_ACTIVE - 1);
      S_VFRONT: w_v_lastidx = VW'(V_FRONT - 1);
      default:  w_v_lastidx = '0;
    endcase
  end

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == w_v_lastidx);

  always_comb begin
    w_state_n = r_state;
    w_h_n     = r_h;
    w_v_n     = r_v;
    if (r_state == S_IDLE) begin
      if (start) begin
        w_state_n = S_VSYNC;
        w_h_n     = '0;
        w_v_n     = '0;
      end
    end else if (w_h_last) begin
      w_h_n = '0;
      if (w_v_last) begin
        w_v_n = '0;
        case (r_state)
          S_VSYNC:  w_state_n = S_VBACK;
          S_VBACK:  w_state_n = S_ACTIVE;
          S_ACTIVE: w_state_n = S_VFRONT;
          S_VFRONT: w_state_n = (r_stop_pend || stop) ? S_IDLE : S_VSYNC;
          default:  w_state_n = S_IDLE;
        endcase
      end else begin
        w_v_n = r_v + VW'(1);
      end
    end else begin
      w_h_n = r_h + HW'(1);
    end
  end

  // Outputs are registered from the next-cycle position so they line up with the FSM registers.
  assign w_vs_n    = (w_state_n == S_VSYNC);
  assign w_hr_n    = (w_state_n == S_ACTIVE) && (32'(w_h_n) < 2 * H_ACTIVE);
  assign pix_ready = w_hr_n && !w_h_n[0] && !r_tp_mode;
  assign w_tp_pix  = {8'(w_v_n), 8'(w_h_n >> 1)};
  assign w_tp_load = ((r_state == S_IDLE) || (r_state == S_VFRONT)) && (w_state_n == S_VSYNC);

  always_comb begin
    w_dout_n = 8'h00;
    w_lo_n   = r_lo;
    w_starve = 1'b0;
    if (w_hr_n) begin
      if (r_tp_mode) begin
        w_dout_n = w_h_n[0] ? w_tp_pix[7:0] : w_tp_pix[15:8];
      end else if (!w_h_n[0]) begin
        if (pix_valid) begin
          w_dout_n = pix[15:8];
          w_lo_n   = pix[7:0];
        end else begin
          // Starved slot: emit zeros for both bytes, never stall the line.
          w_lo_n   = 8'h00;
          w_starve = 1'b1;
        end
      end else begin
        w_dout_n = r_lo;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_h         <= '0;
      r_v         <= '0;
      r_tp_mode   <= 1'b0;
      r_stop_pend <= 1'b0;
      r_lo        <= 8'h00;
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_dout      <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'h0000;
      r_uf_cnt    <= 16'h0000;
      r_uf_err    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_h     <= w_h_n;
      r_v     <= w_v_n;
      r_lo    <= w_lo_n;
      r_vsync <= w_vs_n;
      r_href  <= w_hr_n;
      r_dout  <= w_dout_n;
      r_busy  <= (w_state_n != S_IDLE);
      if (w_tp_load) begin
        r_tp_mode <= tp_en;
      end
      if (w_state_n == S_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (stop && (r_state != S_IDLE)) begin
        r_stop_pend <= 1'b1;
      end
      if ((r_state == S_VFRONT) && w_h_last && w_v_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_starve) begin
        r_uf_err <= 1'b1;
        if (r_uf_cnt != 16'hFFFF) begin
          r_uf_cnt <= r_uf_cnt + 16'd1;
        end
      end
    end
  end

  assign cam_vsync     = r_vsync;
  assign cam_href      = r_href;
  assign cam_dout      = r_dout;
  assign busy          = r_busy;
  assign frame_cnt     = r_frame_cnt;
  assign underflow_cnt = r_uf_cnt;
  assign underflow_err = r_uf_err;

endmodule
